// File: rtl/tile_pkg.sv
// Shared types and helpers for the tile-matching game core.
package tile_pkg;

  typedef enum logic [2:0] {
    MENU     = 3'd0,
    PICK1    = 3'd1,
    PICK2    = 3'd2,
    REVEAL   = 3'd3,
    GAMEOVER = 3'd4
  } tile_state_e;

  localparam logic [2:0] MODE_MENU     = 3'b001;
  localparam logic [2:0] MODE_PLAYING  = 3'b010;
  localparam logic [2:0] MODE_GAMEOVER = 3'b100;

  localparam int DEF_N_TILES      = 10;
  localparam int DEF_COLOR_W      = 4;
  localparam int DEF_SCORE_W      = 8;
  localparam int DEF_BLINK_CYCLES = 25_000_000;
  localparam int DEF_BLINK_COUNT  = 3;

  // Upper bound on tiles handled by the priority encoder below.
  localparam int MAX_TILES = 64;

  typedef struct packed {
    logic       valid;
    logic [5:0] idx;
  } pick_t;

  // Lowest set bit wins; scanning downwards lets the lowest index overwrite.
  function automatic pick_t lowest_set(input logic [MAX_TILES-1:0] vec);
    pick_t r;
    r = '0;
    for (int i = MAX_TILES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.valid = 1'b1;
        r.idx   = 6'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tile_match_engine_flip_detect.sv
// Switch synchroniser and rising-edge detector; reports the lowest-index
// unmasked flip each cycle. Supports up to MAX_TILES switches.
module tile_flip_detect
  import tile_pkg::*;
#(
  parameter int N_TILES = DEF_N_TILES,
  localparam int IDX_W  = (N_TILES > 1) ? $clog2(N_TILES) : 1
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic [N_TILES-1:0] sw,
  input  logic [N_TILES-1:0] mask,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  logic [N_TILES-1:0] sync_a;
  logic [N_TILES-1:0] sync_b;
  logic [N_TILES-1:0] sync_prev;
  logic [N_TILES-1:0] rise_q;
  pick_t              pick;

  // The edge is registered unmasked so masking always uses the current game state.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      sync_a    <= '0;
      sync_b    <= '0;
      sync_prev <= '0;
      rise_q    <= '0;
    end else begin
      sync_a    <= sw;
      sync_b    <= sync_a;
      sync_prev <= sync_b;
      rise_q    <= sync_b & ~sync_prev;
    end
  end

  always_comb begin
    pick  = lowest_set(MAX_TILES'(rise_q & mask));
    valid = pick.valid;
    idx   = IDX_W'(pick.idx);
  end

endmodule

// File: rtl/tile_match_engine.sv
// Tile-matching game core: two flips per move, blinking reveal, then keep
// or turn back the pair; counts moves and flags game-over.
module tile_match_engine
  import tile_pkg::*;
#(
  parameter int N_TILES      = DEF_N_TILES,
  parameter int COLOR_W      = DEF_COLOR_W,
  parameter int SCORE_W      = DEF_SCORE_W,
  parameter int BLINK_CYCLES = DEF_BLINK_CYCLES,
  parameter int BLINK_COUNT  = DEF_BLINK_COUNT
) (
  input  logic                       CLOCK_50,
  input  logic                       resetn,
  input  logic                       start,
  input  logic                       quit,
  input  logic [N_TILES-1:0]         sw,
  input  logic [N_TILES*COLOR_W-1:0] tile_colors,
  output logic [N_TILES-1:0]         led,
  output logic [COLOR_W-1:0]         color1,
  output logic [COLOR_W-1:0]         color2,
  output logic                       show1,
  output logic                       show2,
  output logic [SCORE_W-1:0]         moves,
  output logic [2:0]                 mode,
  output logic                       game_over,
  output tile_state_e                state_dbg
);

  localparam int IDX_W = (N_TILES > 1) ? $clog2(N_TILES) : 1;
  localparam int BT_W  = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int HC_W  = $clog2(2 * BLINK_COUNT + 1);

  tile_state_e        state, state_next;
  logic [N_TILES-1:0] matched;
  logic [N_TILES-1:0] matched_next;
  logic               sel1, sel2;
  logic [IDX_W-1:0]   idx1, idx2;
  logic [BT_W-1:0]    blink_cnt;
  logic [HC_W-1:0]    half_cnt;

  logic [N_TILES-1:0] flip_mask;
  logic [IDX_W-1:0]   flip_idx;
  logic               flip_valid;
  logic [COLOR_W-1:0] flip_color;
  logic [N_TILES-1:0] oh1, oh2;
  logic               blink_wrap, reveal_last, quit_now;

  // The first pick cannot be picked again as the second one.
  always_comb begin
    flip_mask = ~matched;
    if (state == PICK2) flip_mask[idx1] = 1'b0;
  end

  tile_flip_detect #(.N_TILES(N_TILES)) u_flip (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .sw       (sw),
    .mask     (flip_mask),
    .idx      (flip_idx),
    .valid    (flip_valid)
  );

  assign flip_color  = tile_colors[flip_idx*COLOR_W +: COLOR_W];
  assign oh1         = N_TILES'(1) << idx1;
  assign oh2         = N_TILES'(1) << idx2;
  assign blink_wrap  = (blink_cnt == BT_W'(BLINK_CYCLES - 1));
  assign reveal_last = blink_wrap && (half_cnt == HC_W'(2 * BLINK_COUNT - 1));
  assign matched_next = (color1 == color2) ? (matched | oh1 | oh2) : matched;
  assign quit_now    = quit && (state != MENU);

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) state <= MENU;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (quit_now) begin
      state_next = MENU;
    end else begin
      case (state)
        MENU, GAMEOVER: if (start) state_next = PICK1;
        PICK1:          if (flip_valid) state_next = PICK2;
        PICK2:          if (flip_valid) state_next = REVEAL;
        REVEAL:         if (reveal_last) state_next = (&matched_next) ? GAMEOVER : PICK1;
        default:        state_next = MENU;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      matched   <= '0;
      sel1      <= 1'b0;
      sel2      <= 1'b0;
      idx1      <= '0;
      idx2      <= '0;
      color1    <= '0;
      color2    <= '0;
      show1     <= 1'b0;
      show2     <= 1'b0;
      moves     <= '0;
      blink_cnt <= '0;
      half_cnt  <= '0;
    end else if (quit_now) begin
      matched   <= '0;
      sel1      <= 1'b0;
      sel2      <= 1'b0;
      show1     <= 1'b0;
      show2     <= 1'b0;
      blink_cnt <= '0;
      half_cnt  <= '0;
    end else begin
      case (state)
        MENU, GAMEOVER: begin
          if (start) begin
            matched <= '0;
            moves   <= '0;
          end
        end
        PICK1: begin
          if (flip_valid) begin
            idx1   <= flip_idx;
            sel1   <= 1'b1;
            color1 <= flip_color;
            show1  <= 1'b1;
          end
        end
        PICK2: begin
          if (flip_valid) begin
            idx2      <= flip_idx;
            sel2      <= 1'b1;
            color2    <= flip_color;
            show1     <= 1'b1;
            show2     <= 1'b1;
            blink_cnt <= '0;
            half_cnt  <= '0;
            if (moves != '1) moves <= moves + 1'b1;
          end
        end
        REVEAL: begin
          if (!blink_wrap) begin
            blink_cnt <= blink_cnt + 1'b1;
          end else begin
            blink_cnt <= '0;
            if (reveal_last) begin
              matched  <= matched_next;
              sel1     <= 1'b0;
              sel2     <= 1'b0;
              show1    <= 1'b0;
              show2    <= 1'b0;
              half_cnt <= '0;
            end else begin
              half_cnt <= half_cnt + 1'b1;
              show1    <= ~show1;
              show2    <= ~show2;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mode = MODE_MENU;
    case (state)
      PICK1, PICK2, REVEAL: mode = MODE_PLAYING;
      GAMEOVER:             mode = MODE_GAMEOVER;
      default:              mode = MODE_MENU;
    endcase
  end

  assign game_over = (state == GAMEOVER);
  assign led       = game_over ? '1 : (matched | (sel1 ? oh1 : '0) | (sel2 ? oh2 : '0));
  assign state_dbg = state;

endmodule

// File: tb/tb_tile_match_engine.sv
// Directed-plus-random bench for tile_match_engine with a pair-level game model.
module tb_tile_match_engine;
  import tile_pkg::*;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int SW = 2;
  localparam int BC = 3;
  localparam int BN = 2;
  localparam int MOVES_MAX = 2**SW - 1;
  localparam logic [CW-1:0] COL_A = 4'hA;
  localparam logic [CW-1:0] COL_B = 4'h5;

  logic            CLOCK_50 = 1'b0;
  logic            resetn   = 1'b0;
  logic            start    = 1'b0;
  logic            quit     = 1'b0;
  logic [N-1:0]    sw       = '0;
  logic [N*CW-1:0] tile_colors;
  logic [N-1:0]    led;
  logic [CW-1:0]   color1, color2;
  logic            show1, show2;
  logic [SW-1:0]   moves;
  logic [2:0]      mode;
  logic            game_over;
  tile_state_e     state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Game model: which tiles are kept, how many attempts, and each tile colour.
  logic [N-1:0]  m_matched;
  int            m_moves;
  logic [CW-1:0] m_col [N];

  tile_match_engine #(
    .N_TILES(N), .COLOR_W(CW), .SCORE_W(SW), .BLINK_CYCLES(BC), .BLINK_COUNT(BN)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .start       (start),
    .quit        (quit),
    .sw          (sw),
    .tile_colors (tile_colors),
    .led         (led),
    .color1      (color1),
    .color2      (color2),
    .show1       (show1),
    .show2       (show2),
    .moves       (moves),
    .mode        (mode),
    .game_over   (game_over),
    .state_dbg   (state_dbg)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required summary");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle switch pulse; the pick lands on the fourth edge after raising.
  task automatic flip(input int i, input logic [N-1:0] led_before, input logic [N-1:0] led_after);
    sw[i] = 1'b1;
    tick(1);
    sw[i] = 1'b0;
    tick(2);
    chk("led_before_pick", led, led_before);
    tick(1);
    chk("led_after_pick", led, led_after);
  endtask

  task automatic watch_reveal(input logic [N-1:0] sel_led);
    logic e;
    for (int c = 0; c < 2 * BN * BC; c++) begin
      e = ((c / BC) % 2) == 0;
      chk("reveal_show", {show1, show2}, {e, e});
      chk("reveal_led", led, sel_led);
      tick(1);
    end
  endtask

  task automatic end_of_move();
    chk("led_after_move", led, m_matched);
    chk("shows_off", {show1, show2}, 2'b00);
    chk("mode_after_move", mode, (m_matched == '1) ? 3'b100 : 3'b010);
    chk("game_over_after_move", game_over, m_matched == '1);
  endtask

  task automatic attempt(input int a, input int b);
    logic [N-1:0] l1, l2;
    l1 = m_matched | (N'(1) << a);
    l2 = l1 | (N'(1) << b);
    flip(a, m_matched, l1);
    chk("color1", color1, m_col[a]);
    chk("show1_on", show1, 1'b1);
    flip(b, l1, l2);
    chk("color2", color2, m_col[b]);
    m_moves = (m_moves < MOVES_MAX) ? m_moves + 1 : MOVES_MAX;
    chk("moves", moves, m_moves);
    watch_reveal(l2);
    if (m_col[a] == m_col[b]) m_matched = l2;
    end_of_move();
  endtask

  initial begin
    int a, b, t, guard;
    for (int i = 0; i < N; i++) begin
      m_col[i] = (i % 2 == 0) ? COL_A : COL_B;
      tile_colors[i*CW +: CW] = m_col[i];
    end
    m_matched = '0;
    m_moves   = 0;

    resetn = 1'b0;
    tick(3);
    chk("rst_led", led, 4'b0000);
    chk("rst_mode", mode, 3'b001);
    chk("rst_game_over", game_over, 1'b0);
    chk("rst_moves", moves, 0);
    chk("rst_shows", {show1, show2}, 2'b00);
    chk("rst_colors", {color1, color2}, 8'h00);
    chk("rst_state", state_dbg, MENU);
    resetn = 1'b1;
    tick(1);

    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("start_mode", mode, 3'b010);

    attempt(0, 1);
    attempt(0, 2);
    chk("state_pick1", state_dbg, PICK1);

    // sw1 and sw3 rise together: tile 1 wins, the sw3 edge is discarded.
    sw[1] = 1'b1;
    sw[3] = 1'b1;
    tick(1);
    sw[1] = 1'b0;
    tick(3);
    chk("simul_led", led, 4'b0111);
    chk("simul_color1", color1, COL_B);
    tick(4);
    chk("simul_hold_led", led, 4'b0111);
    chk("simul_hold_state", state_dbg, PICK2);
    flip(2, 4'b0111, 4'b0111);
    flip(1, 4'b0111, 4'b0111);
    sw[3] = 1'b0;
    tick(3);
    flip(3, 4'b0111, 4'b1111);
    m_moves = (m_moves < MOVES_MAX) ? m_moves + 1 : MOVES_MAX;
    chk("final_moves", moves, m_moves);
    watch_reveal(4'b1111);
    m_matched = 4'b1111;
    end_of_move();

    // quit outranks start in GAMEOVER; moves survive until the next start.
    quit  = 1'b1;
    start = 1'b1;
    tick(1);
    quit  = 1'b0;
    start = 1'b0;
    m_matched = '0;
    chk("quitstart_mode", mode, 3'b001);
    chk("quitstart_led", led, 4'b0000);
    chk("quitstart_moves", moves, m_moves);

    start = 1'b1;
    tick(1);
    start = 1'b0;
    m_moves = 0;
    chk("restart_moves", moves, 0);
    chk("restart_mode", mode, 3'b010);

    // Random mismatching pairs drive the counter into saturation.
    for (int k = 0; k < 5; k++) begin
      a = 2 * $urandom_range(0, 1);
      b = 2 * $urandom_range(0, 1) + 1;
      if ($urandom_range(0, 1) == 1) begin
        t = a; a = b; b = t;
      end
      attempt(a, b);
      if (k == 0) begin
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("start_ignored_moves", moves, m_moves);
        chk("start_ignored_mode", mode, 3'b010);
      end
    end

    // Random play among unmatched tiles until the board is cleared.
    guard = 0;
    while (m_matched != '1 && guard < 30) begin
      do a = $urandom_range(0, N - 1); while (m_matched[a]);
      do b = $urandom_range(0, N - 1); while (m_matched[b] || b == a);
      attempt(a, b);
      guard++;
    end
    chk("random_game_over", game_over, m_matched == '1);

    start = 1'b1;
    tick(1);
    start = 1'b0;
    m_matched = '0;
    m_moves   = 0;
    chk("newgame_moves", moves, 0);
    chk("newgame_led", led, 4'b0000);
    flip(0, 4'b0000, 4'b0001);
    flip(1, 4'b0001, 4'b0011);
    m_moves = 1;
    tick(5);
    quit = 1'b1;
    tick(1);
    quit = 1'b0;
    chk("quit_mode", mode, 3'b001);
    chk("quit_led", led, 4'b0000);
    chk("quit_shows", {show1, show2}, 2'b00);
    chk("quit_moves", moves, m_moves);
    tick(BC + 1);
    chk("quit_stays_menu", state_dbg, MENU);
    chk("quit_shows_later", {show1, show2}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tile_match_engine.md
# tile_match_engine

Parametrised tile-matching core for the board game: N tiles, each with a colour code, are flipped by rising edges on slide switches. Two flips are compared, revealed with a blinking display window, and then kept (match) or turned back (mismatch). The block counts moves and flags game-over when all tiles are matched. It sits below the top-level mode FSM and drives LEDR, the two tile HEX digits and the score digits through external 7-segment decoders.

## Interface
Parameters:
- N_TILES, 10: number of tiles/switches; must be even and ≥ 2
- COLOR_W, 4: colour code width
- SCORE_W, 8: move counter width
- BLINK_CYCLES, 25_000_000: half-period of the reveal blink, in clocks; must be ≥ 1
- BLINK_COUNT, 3: number of full blink periods per reveal; must be ≥ 1

Ports:
- CLOCK_50  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- start  in  1  single-cycle pulse; begins a new game
- quit  in  1  single-cycle pulse; abandons the game and returns to MENU
- sw  in  N_TILES  raw slide switches, asynchronous
- tile_colors  in  N_TILES*COLOR_W  colour of tile i at bits [i*COLOR_W +: COLOR_W]; static during a game
- led  out  N_TILES  tile lit (matched or currently selected)
- color1, color2  out  COLOR_W each  colours of the first and second selected tile
- show1, show2  out  1 each  HEX digit enable; the blink waveform applies during REVEAL
- moves  out  SCORE_W  completed pair attempts, saturating
- mode  out  3  one-hot {GAMEOVER, PLAYING, MENU}; PLAYING covers PICK1, PICK2 and REVEAL
- game_over  out  1  high in GAMEOVER

## Operation
- States: MENU, PICK1, PICK2, REVEAL, GAMEOVER. Reset enters MENU.
- Reset values: all outputs are 0 except mode = 3'b001. Internal matched, sel1, sel2, idx1, idx2, the timers and the synchroniser flops are also 0.
- Flip event: the synchronised switch i goes from 0 to 1, and tile i is neither matched nor idx1 while in PICK2. A falling switch is ignored.
  - If several events occur in the same cycle, the lowest index wins and the others are discarded.
- MENU: a start pulse clears matched and moves, then moves to PICK1.
- PICK1: on a flip event, idx1 = i, sel1 = 1, color1 = tile_colors[i], show1 = 1, then PICK2.
- PICK2: on a flip event, idx2 = i, sel2 = 1, color2 and show2 update, and moves increments, saturating at 2^SCORE_W − 1. The blink timer is loaded and the state moves to REVEAL.
- REVEAL:
  - show1 and show2 start at 1 and toggle every BLINK_CYCLES clocks, for 2*BLINK_COUNT half-periods in total.
  - Flip events are dropped, but the synchroniser keeps tracking sw, so no stale edge fires afterwards.
  - On the final cycle, a colour match sets matched[idx1] and matched[idx2]. In every case sel1, sel2, show1 and show2 clear.
  - Next state is GAMEOVER if matched becomes all ones, otherwise PICK1.
- GAMEOVER: game_over = 1, led = all ones, and moves holds its value. A start pulse behaves as it does in MENU.
- led = matched | onehot(idx1)&sel1 | onehot(idx2)&sel2.
- quit from any state other than MENU: go to MENU and clear matched, sel1, sel2, show1, show2 and the timers. moves is kept until the next start.
- Precedence: resetn first, then quit, then start. A start pulse outside MENU and GAMEOVER is ignored.

## Timing
- Synchroniser: 2 flops, plus 1 flop for edge detection.
- sw[i] first sampled high at edge k: the edge is detected combinationally after edge k+2, and led[i], sel and color update at edge k+3.
- REVEAL lasts exactly 2*BLINK_COUNT*BLINK_CYCLES cycles. The first REVEAL cycle follows the PICK2 capture edge.
- Blink timer width is clog2(BLINK_CYCLES). The half-period counter width is clog2(2*BLINK_COUNT+1).
- A pulse on start or quit takes effect at the next edge.

## Structure
- Package tile_pkg holds:
  - the state enum, named by state: MENU, PICK1, PICK2, REVEAL, GAMEOVER
  - the mode one-hot constants
  - the default parameter values
  - a function that does a lowest-index priority encode to an index and a valid bit
- Sub-module tile_flip_detect, parametrised by N_TILES: the 2-flop synchroniser, the edge register, and the masked rising-edge vector. Its outputs are the index and valid of the winning event.
- The top level holds the FSM, the blink timers, the move counter and the matched register.

## Test plan
Use N_TILES=4, COLOR_W=4, SCORE_W=2, BLINK_CYCLES=3, BLINK_COUNT=2, and colours {A,B,A,B} for tiles 0..3.
- Reset, then start, then raise sw0: led = 0001 three cycles after the sample, color1 = A, show1 = 1, mode = PLAYING.
- Flip sw0 then sw2: led = 0101, moves = 1, show toggles every 3 cycles for 12 cycles. Afterwards matched = 0101, the state is PICK1, and show1 = show2 = 0.
- Flip sw1 then sw2 (mismatch, tile 2 not yet matched): after reveal, led returns to the prior matched value and moves increments.
- Raise sw1 and sw3 in the same cycle in PICK1: only tile 1 is selected. A later toggle of sw3 (fall then rise) is required before tile 3 can be selected.
- Complete both pairs: game_over = 1 on the edge ending the final REVEAL, and led = 1111. Forcing 5 attempts leaves moves saturated at 3.
- Issue quit during REVEAL: next cycle mode = MENU, and led, show1 and show2 are 0. Issuing quit and start in the same cycle in GAMEOVER results in MENU.
